// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants and queue-occupancy helper for the IF stage
package instr_fetch_unit_pkg;

  localparam int          IMEM_ADDR_WIDTH  = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Occupancy is never stored; it is always derived from the queue count.
  function automatic occ_e occ_of(input int count, input int depth);
    if (count == 0)
      return OCC_EMPTY;
    else if (count >= depth)
      return OCC_FULL;
    else
      return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// rtl/instr_fetch_unit_fetch_queue.sv - small synchronous FIFO of {pc, instr} fetch entries
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [31:0]                push_pc,
  input  logic [31:0]                push_instr,
  input  logic                       pop,
  output logic [31:0]                head_pc,
  output logic [31:0]                head_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  // Pop on empty is ignored; push on full is legal only together with a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < FULL_CNT) || do_pop);

  assign head_pc    = mem_pc[rd_ptr];
  assign head_instr = mem_instr[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_pc[wr_ptr]    <= push_pc;
      mem_instr[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC register, imem fetch, redirect handling, ID handshake
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [IMEM_ADDR_WIDTH-1:0] iaddr,
  input  logic [31:0]                idata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_pc_plus4,
  output logic                       misalign_err,
  output logic [31:0]                fetch_count
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc_reg;
  logic [CW-1:0] q_count;
  logic [31:0]   head_pc;
  logic [31:0]   head_instr;
  logic          push;
  logic          pop;
  occ_e          occ;

  assign occ      = occ_of(int'(q_count), QDEPTH);
  assign id_valid = (occ != OCC_EMPTY);
  assign pop      = id_valid & id_ready;
  // A full queue still accepts a fetch when its head leaves this cycle.
  assign push     = !redirect_valid & ((occ != OCC_FULL) | pop);

  assign iaddr       = pc_reg;
  assign id_instr    = id_valid ? head_instr : NOP_INSTR;
  assign id_pc       = id_valid ? head_pc : 32'h0;
  assign id_pc_plus4 = id_valid ? (head_pc + 32'd4) : 32'h0;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (pc_reg),
    .push_instr (idata),
    .pop        (pop),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (q_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg       <= RESET_PC;
      misalign_err <= 1'b0;
      fetch_count  <= 32'h0;
    end else if (redirect_valid) begin
      pc_reg <= {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00)
        misalign_err <= 1'b1;
    end else if (push) begin
      pc_reg      <= pc_reg + 32'd4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
